// File: rtl/reg_bank_ctrl.sv
// Command-driven initiator for the 16x64 complex register bank: turns single
// commands into write/read port sequences and returns one response per command.
//
// state | meaning
// IDLE  | ready for a command
// WR    | bank write pulse for WRITE
// RD    | bank output-register load pulse (READ, COPY)
// RDW   | bank output registers valid, capture them
// CPWR  | bank write pulse carrying the copied value
// RESP  | response held until rsp_ready
module reg_bank_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_dst,
  input  logic [3:0]       cmd_srcA,
  input  logic [3:0]       cmd_srcB,
  input  logic [1:0]       cmd_end,
  input  logic [63:0]      cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_dataA,
  output logic [63:0]      rsp_dataB,
  output logic             rsp_err,
  output logic [CNT_W-1:0] done_cnt,
  output logic             rb_regwen,
  output logic [63:0]      rb_inA,
  output logic [3:0]       rb_selwreg,
  output logic [1:0]       rb_endwreg,
  output logic [3:0]       rb_seloutA,
  output logic [3:0]       rb_seloutB,
  output logic             rb_cnstA,
  output logic             rb_cnstB,
  output logic             rb_enrregA,
  output logic             rb_enrregB,
  input  logic [63:0]      rb_outA,
  input  logic [63:0]      rb_outB
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;

  typedef enum logic [2:0] {IDLE, WR, RD, RDW, CPWR, RESP} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [3:0]  dst_q;
  logic [1:0]  end_q;
  logic [63:0] cap_a;

  // Constant selects are never used by this initiator.
  assign rb_cnstA = 1'b0;
  assign rb_cnstB = 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      op_q       <= '0;
      dst_q      <= '0;
      end_q      <= '0;
      cap_a      <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_dataA  <= '0;
      rsp_dataB  <= '0;
      rsp_err    <= 1'b0;
      done_cnt   <= '0;
      rb_regwen  <= 1'b0;
      rb_inA     <= '0;
      rb_selwreg <= '0;
      rb_endwreg <= '0;
      rb_seloutA <= '0;
      rb_seloutB <= '0;
      rb_enrregA <= 1'b0;
      rb_enrregB <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            dst_q     <= cmd_dst;
            end_q     <= cmd_end;
            case (cmd_op)
              OP_WRITE: begin
                state      <= WR;
                rb_regwen  <= 1'b1;
                rb_inA     <= cmd_data;
                rb_selwreg <= cmd_dst;
                rb_endwreg <= cmd_end;
              end
              OP_READ: begin
                state      <= RD;
                rb_enrregA <= 1'b1;
                rb_enrregB <= 1'b1;
                rb_seloutA <= cmd_srcA;
                rb_seloutB <= cmd_srcB;
              end
              OP_COPY: begin
                state      <= RD;
                rb_enrregA <= 1'b1;
                rb_seloutA <= cmd_srcA;
              end
              default: begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_dataA <= '0;
                rsp_dataB <= '0;
              end
            endcase
          end
        end
        WR: begin
          rb_regwen <= 1'b0;
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_dataA <= '0;
          rsp_dataB <= '0;
        end
        RD: begin
          rb_enrregA <= 1'b0;
          rb_enrregB <= 1'b0;
          state      <= RDW;
        end
        RDW: begin
          // Bank output registers were loaded at the end of RD and are valid now.
          if (op_q == OP_COPY) begin
            cap_a      <= rb_outA;
            state      <= CPWR;
            rb_regwen  <= 1'b1;
            rb_inA     <= rb_outA;
            rb_selwreg <= dst_q;
            rb_endwreg <= end_q;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_dataA <= rb_outA;
            rsp_dataB <= rb_outB;
          end
        end
        CPWR: begin
          rb_regwen <= 1'b0;
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_dataA <= cap_a;
          rsp_dataB <= '0;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dataA <= '0;
            rsp_dataB <= '0;
            cmd_ready <= 1'b1;
            done_cnt  <= done_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
